// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised UART transmitter. It contains the frame FSM, the baud
// timer and the shift register in one block.
// A frame is sent LSB-first as: start, WORD_LENGTH data bits, optional parity, then
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT cycles. All outputs are registered.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
// PARITY_ODD selects even (0) or odd (1) parity.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  S_IDLE   | line high, waiting for transmit
//  S_START  | start bit (tx=0)
//  S_DATA   | data bits, LSB first, from r_shift[0]
//  S_PARITY | parity bit of the word captured at acceptance (macro only)
//  S_STOP   | STOP_BITS stop bits (tx=1); done pulses on the last boundary
module uart_tx_engine #(
   parameter int WORD_LENGTH  = 8,
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   transmit,
   input  logic [WORD_LENGTH-1:0] data_in,
   output logic                   tx,
   output logic                   busy,
   output logic                   done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(WORD_LENGTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WORD_LENGTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   // Reject illegal parameter combinations when the design is elaborated.
   if (WORD_LENGTH < 5 || WORD_LENGTH > 9) begin : g_bad_word_length
      $error("uart_tx_engine: WORD_LENGTH must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_engine: CLKS_PER_BIT must be >= 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_engine: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_engine: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [BAUD_W-1:0]      r_baud, w_baud_nxt;
   logic [BIT_W-1:0]       r_bit, w_bit_nxt;
   logic [WORD_LENGTH-1:0] r_shift, w_shift_nxt;
   logic                   r_tx, w_tx_nxt;
   logic                   r_busy, w_busy_nxt;
   logic                   r_done, w_done_nxt;
   logic                   w_tick;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity, w_parity_nxt;
`endif

   assign w_tick = (r_baud == BAUD_LAST);

   // State register and registered outputs. Reset abandons any frame in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bit    <= w_bit_nxt;
         r_shift  <= w_shift_nxt;
         r_tx     <= w_tx_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity <= w_parity_nxt;
`endif
      end
   end

   // Next-state logic and the next values of the registered outputs.
   // r_bit counts data bits in S_DATA and is reused to count stop bits in S_STOP.
   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = r_baud;
      w_bit_nxt    = r_bit;
      w_shift_nxt  = r_shift;
      w_tx_nxt     = r_tx;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      case (r_state)
         S_IDLE: begin
            w_tx_nxt   = 1'b1;
            w_busy_nxt = 1'b0;
            if (transmit) begin
               w_state_nxt  = S_START;
               w_shift_nxt  = data_in;
               w_tx_nxt     = 1'b0;
               w_busy_nxt   = 1'b1;
               w_baud_nxt   = '0;
               w_bit_nxt    = '0;
`ifdef UART_TX_PARITY_EN
               w_parity_nxt = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
`endif
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = '0;
               w_tx_nxt    = r_shift[0];
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_baud_nxt = '0;
               if (r_bit == DATA_LAST) begin
                  w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
                  w_tx_nxt    = r_parity;
`else
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
`endif
               end else begin
                  w_bit_nxt   = r_bit + 1'b1;
                  w_shift_nxt = r_shift >> 1;
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_tick) begin
               w_state_nxt = S_STOP;
               w_baud_nxt  = '0;
               w_tx_nxt    = 1'b1;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
`endif
         S_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_tick) begin
               w_baud_nxt = '0;
               if (r_bit == STOP_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_bit_nxt   = '0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine with CLKS_PER_BIT=4 and WORD_LENGTH=8.
// u_dut uses one stop bit and even parity. u_dut2 uses two stop bits and odd parity.
// Frame patterns are listed as {stop(s), [parity], d7..d0, start}, so bit k of the
// pattern is the line level during serial bit k.
module tb_uart_tx_engine;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB1 = 10 + P;
   localparam int NB2 = 11 + P;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       transmit, transmit2;
   logic [7:0] data_in, data_in2;
   logic       tx, busy, done, tx2, busy2, done2;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  data;
      logic [11:0] frame;
   } vec_t;
   vec_t       vecs[5];
   logic [11:0] frame2_07;

   always #5 clk = ~clk;

   uart_tx_engine #(.WORD_LENGTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
      .clk(clk), .reset(reset), .transmit(transmit), .data_in(data_in),
      .tx(tx), .busy(busy), .done(done));

   uart_tx_engine #(.WORD_LENGTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
      .clk(clk), .reset(reset), .transmit(transmit2), .data_in(data_in2),
      .tx(tx2), .busy(busy2), .done(done2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, " tx"}, tx, 1);
      chk({name, " busy"}, busy, 0);
      chk({name, " done"}, done, 0);
   endtask

   // Make a one-cycle request. Return at the negedge just after the accept edge.
   task automatic send(input bit sel, input logic [7:0] d);
      @(negedge clk);
      if (sel) begin transmit2 = 1'b1; data_in2 = d; end
      else     begin transmit  = 1'b1; data_in  = d; end
      @(negedge clk);
      transmit  = 1'b0;
      transmit2 = 1'b0;
   endtask

   // Start at cycle 0 after accept. Check every cycle of the frame, then the done cycle.
   task automatic check_frame(input string name, input bit sel, input logic [11:0] frame,
                              input int nbits);
      for (int k = 0; k < nbits * CPB; k++) begin
         chk($sformatf("%s tx c%0d", name, k), sel ? tx2 : tx, frame[k / CPB]);
         chk($sformatf("%s busy c%0d", name, k), sel ? busy2 : busy, 1);
         chk($sformatf("%s done c%0d", name, k), sel ? done2 : done, 0);
         @(negedge clk);
      end
      chk({name, " done pulse"}, sel ? done2 : done, 1);
      chk({name, " busy end"}, sel ? busy2 : busy, 0);
      chk({name, " tx end"}, sel ? tx2 : tx, 1);
   endtask

   initial begin
      int cnt, len, ones;
      transmit = 1'b0; transmit2 = 1'b0; data_in = '0; data_in2 = '0;
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'h55, 12'b1_0_01010101_0};
      vecs[1] = '{8'hA3, 12'b1_0_10100011_0};
      vecs[2] = '{8'h07, 12'b1_1_00000111_0};
      vecs[3] = '{8'h3C, 12'b1_0_00111100_0};
      vecs[4] = '{8'hFF, 12'b1_0_11111111_0};
      frame2_07 = 12'b1_1_0_00000111_0;
`else
      vecs[0] = '{8'h55, 12'b1_01010101_0};
      vecs[1] = '{8'hA3, 12'b1_10100011_0};
      vecs[2] = '{8'h07, 12'b1_00000111_0};
      vecs[3] = '{8'h3C, 12'b1_00111100_0};
      vecs[4] = '{8'hFF, 12'b1_11111111_0};
      frame2_07 = 12'b1_1_00000111_0;
`endif

      // Reset state, then a reset in the middle of a frame and a quiet line afterwards.
      repeat (3) @(negedge clk);
      chk_idle("in reset");
      reset = 1'b1;
      @(negedge clk);
      chk_idle("after reset");
      send(0, 8'h55);
      repeat (6) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_idle("async reset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_idle($sformatf("quiet c%0d", i));
      end

      // Frames from the vector table.
      for (int i = 0; i < 5; i++) begin
         send(0, vecs[i].data);
         check_frame($sformatf("vec%0d", i), 0, vecs[i].frame, NB1);
         @(negedge clk);
         chk($sformatf("vec%0d done clear", i), done, 0);
      end

      // A request made while busy is ignored and its data is never used.
      send(0, 8'hA3);
      fork
         check_frame("ignore", 0, vecs[1].frame, NB1);
         begin
            repeat (8) @(negedge clk);
            transmit = 1'b1; data_in = 8'hFF;
            repeat (10) @(negedge clk);
            transmit = 1'b0;
         end
      join
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk_idle($sformatf("ignore idle c%0d", i));
      end

      // Reset 17 cycles into a frame: the frame is dropped with no done pulse.
      send(0, 8'hA3);
      repeat (17) @(negedge clk);
      chk("pre-reset tx", tx, 0);
      chk("pre-reset busy", busy, 1);
      #2 reset = 1'b0;
      #1 chk_idle("mid reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_idle($sformatf("held reset c%0d", i));
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_idle($sformatf("post reset c%0d", i));
      end
      send(0, 8'h3C);
      check_frame("after reset 3C", 0, vecs[3].frame, NB1);

      // Two stop bits and odd parity on the second instance.
      send(1, 8'h07);
      check_frame("dut2 07", 1, frame2_07, NB2);

      // Transmit held high continuously: one gap cycle between frames.
      @(negedge clk);
      transmit2 = 1'b1; data_in2 = 8'h00;
      cnt = 0;
      while (!done2 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("first done seen", (cnt < 100), 1);
      for (int f = 0; f < 3; f++) begin
         chk($sformatf("gap tx f%0d", f), tx2, 1);
         len = 0; ones = 0;
         do begin
            ones += tx2;
            @(negedge clk);
            len++;
            if (len == 1) chk($sformatf("start after gap f%0d", f), tx2, 0);
         end while (!done2 && len < 200);
         chk($sformatf("done period f%0d", f), len, 45 + 4 * P);
         chk($sformatf("high cycles f%0d", f), ones, 9 + 4 * P);
      end
      transmit2 = 1'b0;
      repeat (60) @(negedge clk);
      chk("dut2 idle busy", busy2, 0);
      chk("dut2 idle tx", tx2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
